pc_pipe_tracker: RTL and testbench

Parametrised PC-tracking pipeline that carries each fetched instruction's PC, with a valid bit, from fetch through a configurable number of pipeline stages. It has per-stage stall and flush and a selectable output tap. It sits beside the main pipeline registers and feeds the register-file write path with the PC, or the link address, of the instruction at the tap stage. Unlike a plain PC shift chain, it inserts bubbles behind a stalled stage and kills squashed instructions, so the tapped PC always corresponds to a live instruction.

---
 rtl/pc_pipe_pkg.sv | 18 +
 rtl/pc_pipe_if.sv | 29 ++
 rtl/pc_pipe_stage.sv | 31 +++
 rtl/pc_pipe_tracker.sv | 71 +++++++
 tb/tb_pc_pipe_tracker.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pc_pipe_pkg.sv
// Shared constants and types for the PC-tracking pipeline.
package pc_pipe_pkg;

  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;

  localparam int PC_W     = 32;
  localparam int LINK_OFS = 8;

  // Per-stage control seen by one pc_pipe_stage, in priority order flush > stall > bubble.
  typedef struct packed {
    logic flush;
    logic stall;
    logic bubble;
  } stage_ctrl_t;

endpackage

// File: rtl/pc_pipe_if.sv
// Bus bundle for pc_pipe_tracker: fetch-side inputs, stall/flush vectors and tap outputs.
interface pc_pipe_if #(
  parameter int WIDTH = pc_pipe_pkg::PC_W,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       in_pc;
  logic                   in_valid;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH*WIDTH-1:0] stage_pc;
  logic [DEPTH-1:0]       stage_valid;
  logic [WIDTH-1:0]       out_pc;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_link;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output in_pc, in_valid, stall, flush,
    input  stage_pc, stage_valid, out_pc, out_valid, out_link, occupancy
  );

  modport slave (
    input  in_pc, in_valid, stall, flush,
    output stage_pc, stage_valid, out_pc, out_valid, out_link, occupancy
  );

endinterface

// File: rtl/pc_pipe_stage.sv
// One tracked stage: a PC register plus valid bit with reset > flush > stall > bubble > advance.
module pc_pipe_stage
  import pc_pipe_pkg::*;
#(
  parameter int WIDTH = PC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  stage_ctrl_t      ctrl,
  input  logic [WIDTH-1:0] src_pc,
  input  logic             src_valid,
  output logic [WIDTH-1:0] pc,
  output logic             valid
);

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value, which is what makes the chain shift correctly.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      valid <= 1'b0;
    end else if (ctrl.flush) begin
      valid <= 1'b0;
    end else if (!ctrl.stall) begin
      // A bubble still copies the upstream PC; only the valid bit is suppressed.
      pc    <= src_pc;
      valid <= src_valid & ~ctrl.bubble;
    end
  end

endmodule

// File: rtl/pc_pipe_tracker.sv
// PC/valid tracker beside the main pipeline with per-stage stall/flush and an output tap.
// Define PC_PIPE_LINK_EN to build the link adder (out_link = out_pc + LINK_OFFSET).
module pc_pipe_tracker
  import pc_pipe_pkg::*;
#(
  parameter int WIDTH       = PC_W,
  parameter int DEPTH       = 3,
  parameter int TAP         = DEPTH - 1,
  parameter int LINK_OFFSET = LINK_OFS
) (
  input logic      clk,
  input logic      reset,
  pc_pipe_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [OCC_W-1:0] occ;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] src_pc;
    logic             src_valid;

    if (k == STG_IFID) begin : g_head
      assign src_pc    = bus.in_pc;
      assign src_valid = bus.in_valid;
      assign ctrl      = '{flush: bus.flush[k], stall: bus.stall[k], bubble: 1'b0};
    end else begin : g_tail
      // Upstream held while this stage is free: take a bubble instead of duplicating.
      assign src_pc    = pc_q[k-1];
      assign src_valid = valid_q[k-1];
      assign ctrl      = '{flush: bus.flush[k], stall: bus.stall[k], bubble: bus.stall[k-1]};
    end

    pc_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .ctrl      (ctrl),
      .src_pc    (src_pc),
      .src_valid (src_valid),
      .pc        (pc_q[k]),
      .valid     (valid_q[k])
    );

    assign bus.stage_pc[k*WIDTH +: WIDTH] = pc_q[k];
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(valid_q[k]);
    end
  end

  assign bus.stage_valid = valid_q;
  assign bus.occupancy   = occ;
  assign bus.out_pc      = pc_q[TAP];
  assign bus.out_valid   = valid_q[TAP];

`ifdef PC_PIPE_LINK_EN
  localparam logic [WIDTH-1:0] LINK_ADD = WIDTH'(LINK_OFFSET);
  assign bus.out_link = bus.out_pc + LINK_ADD;
`else
  assign bus.out_link = bus.out_pc;
`endif

endmodule

// File: tb/tb_pc_pipe_tracker.sv
// Directed bench for pc_pipe_tracker with default parameters; expected values are hand-computed.
module tb_pc_pipe_tracker;
  import pc_pipe_pkg::*;

  localparam int W = 32;
  localparam int D = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  pc_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  pc_pipe_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply the current inputs across one rising edge, then settle before sampling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] pc, input logic v,
                       input logic [D-1:0] st, input logic [D-1:0] fl);
    bus.in_pc    = pc;
    bus.in_valid = v;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  function automatic logic [W-1:0] exp_link(input logic [W-1:0] pc);
`ifdef PC_PIPE_LINK_EN
    return pc + W'(LINK_OFS);
`else
    return pc;
`endif
  endfunction

  initial begin
    // Reset then idle
    reset = 1'b1;
    drive('0, 1'b0, '0, '0);
    cyc();
    check("rst_valid", 64'(bus.stage_valid), 64'h0);
    check("rst_occ",   64'(bus.occupancy),   64'h0);
    check("rst_outpc", 64'(bus.out_pc),      64'h0);
    check("rst_outv",  64'(bus.out_valid),   64'h0);
    check("rst_link",  64'(bus.out_link),    64'(exp_link('0)));
    reset = 1'b0;

    // Straight flow: one token through stages 0,1,2
    drive(32'h0040_0000, 1'b1, '0, '0);
    cyc();
    check("flow_e0_v",   64'(bus.stage_valid), 64'b001);
    check("flow_e0_occ", 64'(bus.occupancy),   64'd1);
    check("flow_e0_pc0", 64'(bus.stage_pc[STG_IFID*W +: W]), 64'h0040_0000);
    bus.in_valid = 1'b0;
    cyc();
    check("flow_e1_v",   64'(bus.stage_valid), 64'b010);
    check("flow_e1_occ", 64'(bus.occupancy),   64'd1);
    check("flow_e1_out", 64'(bus.out_valid),   64'd0);
    cyc();
    check("flow_e2_v",   64'(bus.stage_valid), 64'b100);
    check("flow_e2_occ", 64'(bus.occupancy),   64'd1);
    check("flow_e2_pc",  64'(bus.out_pc),      64'h0040_0000);
    check("flow_e2_ov",  64'(bus.out_valid),   64'd1);
    check("flow_e2_lnk", 64'(bus.out_link),    64'(exp_link(32'h0040_0000)));
    cyc();
    check("flow_drain",  64'(bus.occupancy),   64'd0);

    // IF/ID stall for two cycles with 0x100 in stage 0
    drive(32'h100, 1'b1, '0, '0);
    cyc();
    drive(32'h999, 1'b0, 3'b001, '0);
    cyc();
    check("ifst1_pc0", 64'(bus.stage_pc[0*W +: W]), 64'h100);
    check("ifst1_v",   64'(bus.stage_valid),        64'b001);
    check("ifst1_pc1", 64'(bus.stage_pc[1*W +: W]), 64'h100);
    cyc();
    check("ifst2_pc0", 64'(bus.stage_pc[0*W +: W]), 64'h100);
    check("ifst2_v",   64'(bus.stage_valid),        64'b001);
    bus.stall = '0;
    cyc();
    check("ifrel_v",   64'(bus.stage_valid),        64'b010);
    check("ifrel_pc1", 64'(bus.stage_pc[1*W +: W]), 64'h100);
    check("ifrel_ov",  64'(bus.out_valid),          64'd0);
    cyc();
    check("ifout_pc",  64'(bus.out_pc),    64'h100);
    check("ifout_ov",  64'(bus.out_valid), 64'd1);
    cyc();

    // Flush beats stall in stage 1
    drive(32'h200, 1'b1, '0, '0);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    check("fs_pre_v",  64'(bus.stage_valid),        64'b010);
    drive(32'h300, 1'b0, 3'b010, 3'b010);
    cyc();
    check("fs_v1",     64'(bus.stage_valid[1]),     64'd0);
    check("fs_pc1",    64'(bus.stage_pc[1*W +: W]), 64'h200);
    check("fs_v2",     64'(bus.stage_valid[2]),     64'd0);
    check("fs_occ",    64'(bus.occupancy),          64'd0);

    // Fill three stages, stall the last, then reset mid-stream
    drive(32'hA00, 1'b1, '0, '0);
    cyc();
    bus.in_pc = 32'hA04;
    cyc();
    bus.in_pc = 32'hA08;
    cyc();
    check("full_occ",  64'(bus.occupancy), 64'd3);
    check("full_out",  64'(bus.out_pc),    64'hA00);
    drive(32'hA0C, 1'b0, 3'b100, '0);
    cyc();
    check("st2_out",   64'(bus.out_pc),    64'hA00);
    check("st2_v",     64'(bus.stage_valid), 64'b110);
    check("st2_pc1",   64'(bus.stage_pc[1*W +: W]), 64'hA08);
    check("st2_occ",   64'(bus.occupancy), 64'd2);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    check("mrst_v",    64'(bus.stage_valid), 64'b000);
    check("mrst_occ",  64'(bus.occupancy),   64'd0);
    check("mrst_pcs",  64'(bus.stage_pc),    64'h0);
    reset = 1'b0;

    // Link wrap at the top of the address space
    drive(32'hFFFF_FFFC, 1'b1, '0, '0);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    cyc();
    check("wrap_pc",   64'(bus.out_pc),   64'hFFFF_FFFC);
    check("wrap_ov",   64'(bus.out_valid), 64'd1);
`ifdef PC_PIPE_LINK_EN
    check("wrap_link", 64'(bus.out_link), 64'h0000_0004);
`else
    check("wrap_link", 64'(bus.out_link), 64'hFFFF_FFFC);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
